// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: MEM-stage load/store controller for a variable-latency data memory.
// Formats byte/half/word accesses and holds the instruction in MEM until the response returns.
// Misaligned or illegal accesses are flagged without touching memory.
// An access that outlives the timeout budget ends with a bus error.
//
// state  | meaning
// S_IDLE | no access in flight; a legal, aligned access starts here
// S_REQ  | request on the bus, waiting for grant
// S_WAIT | granted, waiting for the response
// S_DONE | result presented for one cycle, pipeline released
module lsu_mem_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_lsu_valid,
    input  logic        i_lsu_wren,
    input  logic [2:0]  i_lsu_funct3,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_lsu_wdata,
    output logic        o_stall_lsu,
    output logic [31:0] o_ld_data,
    output logic        o_lsu_exc,
    output logic        o_bus_err,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   ld_q;
    logic          err_q;

    logic          illegal;
    logic          misaligned;
    logic          access_ok;
    logic          timeout_hit;
    logic [3:0]    be;
    logic [31:0]   wdata_rep;
    logic [31:0]   ld_fmt;

    // Classify the MEM-stage access: legal size/sign code and natural alignment
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        if (i_lsu_wren)
            illegal = i_lsu_funct3[2] | (i_lsu_funct3[1:0] == 2'b11);
        else
            illegal = (i_lsu_funct3 == 3'b011) | (i_lsu_funct3[2:1] == 2'b11);
        case (i_lsu_funct3[1:0])
            2'b01:   misaligned = i_lsu_addr[0];
            2'b10:   misaligned = (i_lsu_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    assign access_ok   = i_lsu_valid & ~illegal & ~misaligned;
    assign timeout_hit = (cnt >= CW'(TIMEOUT_CYCLES - 1));

    // Byte enables and lane-replicated store data from the access size
    always_comb begin
        be        = 4'b1111;
        wdata_rep = i_lsu_wdata;
        case (i_lsu_funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << i_lsu_addr[1:0];
                wdata_rep = {4{i_lsu_wdata[7:0]}};
            end
            2'b01: begin
                be        = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{i_lsu_wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = i_lsu_wdata;
            end
        endcase
    end

    // Load formatting: pick the addressed lane, then sign- or zero-extend
    always_comb begin
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        lane_b = 8'h00;
        lane_h = 16'h0000;
        ld_fmt = i_mem_rdata;
        case (i_lsu_addr[1:0])
            2'b00:   lane_b = i_mem_rdata[7:0];
            2'b01:   lane_b = i_mem_rdata[15:8];
            2'b10:   lane_b = i_mem_rdata[23:16];
            default: lane_b = i_mem_rdata[31:24];
        endcase
        lane_h = i_lsu_addr[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        case (i_lsu_funct3)
            3'b000:  ld_fmt = {{24{lane_b[7]}}, lane_b};
            3'b001:  ld_fmt = {{16{lane_h[15]}}, lane_h};
            3'b100:  ld_fmt = {24'h000000, lane_b};
            3'b101:  ld_fmt = {16'h0000, lane_h};
            default: ld_fmt = i_mem_rdata;
        endcase
    end

    // Access sequencer with timeout counter and captured result
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            ld_q  <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (access_ok) begin
                        state <= S_REQ;
                        cnt   <= '0;
                        err_q <= 1'b0;
                    end
                end
                S_REQ: begin
                    cnt <= cnt + 1'b1;
                    if (i_mem_gnt) begin
                        state <= S_WAIT;
                    end else if (timeout_hit) begin
                        state <= S_DONE;
                        err_q <= 1'b1;
                        ld_q  <= '0;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (i_mem_rvalid) begin
                        state <= S_DONE;
                        ld_q  <= i_lsu_wren ? 32'h0 : ld_fmt;
                    end else if (timeout_hit) begin
                        state <= S_DONE;
                        err_q <= 1'b1;
                        ld_q  <= '0;
                    end
                end
                default: begin
                    // The instruction retires here; it is never re-issued.
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Stall is combinational in IDLE so the hazard unit freezes in the first cycle
    assign o_stall_lsu = i_reset & (((state == S_IDLE) & access_ok) |
                                    (state == S_REQ) | (state == S_WAIT));
    assign o_lsu_exc   = i_reset & (state == S_IDLE) & i_lsu_valid & (illegal | misaligned);
    assign o_ld_data   = (i_reset && state == S_DONE) ? ld_q : 32'h0;
    assign o_bus_err   = i_reset & (state == S_DONE) & err_q;
    assign o_mem_req   = i_reset & (state == S_REQ);
    assign o_mem_we    = i_reset & i_lsu_wren;
    assign o_mem_addr  = i_reset ? {i_lsu_addr[31:2], 2'b00} : 32'h0;
    assign o_mem_be    = i_reset ? be : 4'h0;
    assign o_mem_wdata = i_reset ? wdata_rep : 32'h0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a small bus responder driven from the access task.
module tb_lsu_mem_ctrl;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_lsu_valid;
    logic        i_lsu_wren;
    logic [2:0]  i_lsu_funct3;
    logic [31:0] i_lsu_addr;
    logic [31:0] i_lsu_wdata;
    logic        o_stall_lsu;
    logic [31:0] o_ld_data;
    logic        o_lsu_exc;
    logic        o_bus_err;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic        i_mem_gnt;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;

    int checks   = 0;
    int failures = 0;

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_lsu_valid  (i_lsu_valid),
        .i_lsu_wren   (i_lsu_wren),
        .i_lsu_funct3 (i_lsu_funct3),
        .i_lsu_addr   (i_lsu_addr),
        .i_lsu_wdata  (i_lsu_wdata),
        .o_stall_lsu  (o_stall_lsu),
        .o_ld_data    (o_ld_data),
        .o_lsu_exc    (o_lsu_exc),
        .o_bus_err    (o_bus_err),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_be     (o_mem_be),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_gnt    (i_mem_gnt),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Entered 1 time unit after a rising edge. Samples mid-cycle; grants on request
    // number gnt_dly+1 (never if negative) and returns rvalid on WAIT cycle rv_dly+1.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int gnt_dly, input int rv_dly,
                          output int stall_n, output int req_n, output int exc_n,
                          output logic [31:0] ld, output logic [3:0] be,
                          output logic [31:0] mwd, output logic err, output logic mwe);
        int  wait_n;
        bit  granted;
        bit  done;
        stall_n = 0; req_n = 0; exc_n = 0;
        ld = '0; be = '0; mwd = '0; err = 1'b0; mwe = 1'b0;
        wait_n = 0; granted = 1'b0; done = 1'b0;
        i_lsu_valid  = 1'b1;
        i_lsu_wren   = we;
        i_lsu_funct3 = f3;
        i_lsu_addr   = addr;
        i_lsu_wdata  = wd;
        i_mem_rdata  = rd;
        i_mem_gnt    = 1'b0;
        i_mem_rvalid = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            #4;
            if (o_lsu_exc)   exc_n++;
            if (o_stall_lsu) stall_n++;
            if (o_mem_req) begin
                req_n++;
                be  = o_mem_be;
                mwd = o_mem_wdata;
                mwe = o_mem_we;
                if (gnt_dly >= 0 && req_n > gnt_dly) begin
                    i_mem_gnt = 1'b1;
                    granted   = 1'b1;
                end
            end else if (granted && o_stall_lsu) begin
                wait_n++;
                if (wait_n > rv_dly) i_mem_rvalid = 1'b1;
            end
            if (!o_stall_lsu) begin
                done = 1'b1;
                ld   = o_ld_data;
                err  = o_bus_err;
            end
            @(posedge i_clk);
            #1;
            i_mem_gnt    = 1'b0;
            i_mem_rvalid = 1'b0;
            if (done) i_lsu_valid = 1'b0;
        end
        if (!done) chk("access_bound", {31'h0, done}, 32'h1);
        i_lsu_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int          s, r, e;
        logic [31:0] ld, mwd;
        logic [3:0]  be;
        logic        err, mwe;

        i_reset      = 1'b0;
        i_lsu_valid  = 1'b0;
        i_lsu_wren   = 1'b0;
        i_lsu_funct3 = 3'b010;
        i_lsu_addr   = 32'h0;
        i_lsu_wdata  = 32'h0;
        i_mem_gnt    = 1'b0;
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = 32'h0;

        // Outputs forced low while reset is held, even with a valid access present
        @(posedge i_clk); #1;
        i_lsu_valid = 1'b1;
        i_lsu_addr  = 32'h0000_0100;
        @(posedge i_clk); #1;
        #3;
        chk("rst_stall", {31'h0, o_stall_lsu}, 32'h0);
        chk("rst_addr",  o_mem_addr, 32'h0);
        chk("rst_be",    {28'h0, o_mem_be}, 32'h0);
        chk("rst_req",   {31'h0, o_mem_req}, 32'h0);
        @(posedge i_clk); #1;
        i_lsu_valid = 1'b0;
        i_reset     = 1'b1;
        @(posedge i_clk); #1;

        // LW minimum latency
        access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, s, r, e, ld, be, mwd, err, mwe);
        chk("lw_stall", s, 3);
        chk("lw_data",  ld, 32'hDEADBEEF);
        chk("lw_be",    {28'h0, be}, 32'hF);
        chk("lw_err",   {31'h0, err}, 32'h0);

        // LB / LBU top lane
        access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 0, 0, s, r, e, ld, be, mwd, err, mwe);
        chk("lb_be",   {28'h0, be}, 32'h8);
        chk("lb_data", ld, 32'hFFFFFF80);
        access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 0, 0, s, r, e, ld, be, mwd, err, mwe);
        chk("lbu_data", ld, 32'h00000080);

        // LH upper half sign-extended, LHU lower half zero-extended
        access(1'b0, 3'b001, 32'h102, 32'h0, 32'h80011234, 1, 2, s, r, e, ld, be, mwd, err, mwe);
        chk("lh_be",   {28'h0, be}, 32'hC);
        chk("lh_data", ld, 32'hFFFF8001);
        access(1'b0, 3'b101, 32'h100, 32'h0, 32'h0000F00D, 0, 0, s, r, e, ld, be, mwd, err, mwe);
        chk("lhu_be",   {28'h0, be}, 32'h3);
        chk("lhu_data", ld, 32'h0000F00D);

        // SH with slow grant and response
        access(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 4, 1, s, r, e, ld, be, mwd, err, mwe);
        chk("sh_be",    {28'h0, be}, 32'hC);
        chk("sh_wdata", mwd, 32'hABCDABCD);
        chk("sh_stall", s, 8);
        chk("sh_data",  ld, 32'h0);
        chk("sh_we",    {31'h0, mwe}, 32'h1);

        // SB lane 1
        access(1'b1, 3'b000, 32'h201, 32'h0000005A, 32'h0, 0, 0, s, r, e, ld, be, mwd, err, mwe);
        chk("sb_be",    {28'h0, be}, 32'h2);
        chk("sb_wdata", mwd, 32'h5A5A5A5A);

        // Misaligned and illegal accesses: exception, no request, no stall
        access(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0, s, r, e, ld, be, mwd, err, mwe);
        chk("mis_exc",   e, 1);
        chk("mis_req",   r, 0);
        chk("mis_stall", s, 0);
        access(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, s, r, e, ld, be, mwd, err, mwe);
        chk("ill_exc", e, 1);
        chk("ill_req", r, 0);
        access(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 0, s, r, e, ld, be, mwd, err, mwe);
        chk("ill_st_exc", e, 1);
        access(1'b1, 3'b001, 32'h203, 32'h0, 32'h0, 0, 0, s, r, e, ld, be, mwd, err, mwe);
        chk("mis_sh_exc", e, 1);

        // Timeout: no grant ever
        access(1'b0, 3'b010, 32'h300, 32'h0, 32'h12345678, -1, 0, s, r, e, ld, be, mwd, err, mwe);
        chk("to_req",   r, 8);
        chk("to_err",   {31'h0, err}, 32'h1);
        chk("to_data",  ld, 32'h0);
        chk("to_stall", s, 9);
        #4;
        chk("to_idle_err", {31'h0, o_bus_err}, 32'h0);
        @(posedge i_clk); #1;

        // Reset during WAIT, then a late rvalid must be ignored
        i_lsu_valid  = 1'b1;
        i_lsu_wren   = 1'b0;
        i_lsu_funct3 = 3'b010;
        i_lsu_addr   = 32'h100;
        @(posedge i_clk); #1;
        i_mem_gnt = 1'b1;
        @(posedge i_clk); #1;
        i_mem_gnt = 1'b0;
        #1;
        chk("rw_wait_stall", {31'h0, o_stall_lsu}, 32'h1);
        i_reset = 1'b0;
        #3;
        chk("rw_rst_stall", {31'h0, o_stall_lsu}, 32'h0);
        chk("rw_rst_req",   {31'h0, o_mem_req}, 32'h0);
        @(posedge i_clk); #1;
        i_lsu_valid = 1'b0;
        i_reset     = 1'b1;
        @(posedge i_clk); #1;
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'hCAFEF00D;
        #3;
        chk("rw_late_stall", {31'h0, o_stall_lsu}, 32'h0);
        @(posedge i_clk); #1;
        i_mem_rvalid = 1'b0;
        #3;
        chk("rw_late_data", o_ld_data, 32'h0);
        chk("rw_late_req",  {31'h0, o_mem_req}, 32'h0);
        chk("rw_late_err",  {31'h0, o_bus_err}, 32'h0);

        // Controller still works after the aborted access
        @(posedge i_clk); #1;
        access(1'b0, 3'b010, 32'h104, 32'h0, 32'h0BADF00D, 0, 0, s, r, e, ld, be, mwd, err, mwe);
        chk("post_stall", s, 3);
        chk("post_data",  ld, 32'h0BADF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
